// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one active-low column at a time, synchronises the
// active-low row lines, and debounces every key independently into a level vector.
module keypad_scanner #(
    parameter int unsigned Rows          = 4,
    parameter int unsigned Cols          = 4,
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned DebounceScans = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [Rows-1:0]        rows_i,
    output logic [Cols-1:0]        cols_o,
    output logic [Rows*Cols-1:0]   buttons_o,
    output logic                   scan_done_o
);

    localparam int unsigned Keys = Rows * Cols;
    localparam int unsigned ColW = (Cols > 1) ? $clog2(Cols) : 1;
    localparam int unsigned SetW = $clog2(SettleCycles);
    localparam int unsigned CntW = $clog2(DebounceScans + 1);

    localparam logic [SetW-1:0] SettleLast = SetW'(SettleCycles - 1);
    localparam logic [ColW-1:0] ColLast    = ColW'(Cols - 1);
    localparam logic [CntW-1:0] CntLast    = CntW'(DebounceScans - 1);

    logic [Rows-1:0]            rows_meta_q;
    logic [Rows-1:0]            rows_s_q;
    logic [ColW-1:0]            col_q, col_d;
    logic [SetW-1:0]            settle_q, settle_d;
    logic [Keys-1:0]            stable_q, stable_d;
    logic [Keys-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic                       done_q, done_d;

    logic                       sample_en;
    logic [Rows-1:0]            pressed_raw;

    // Rows read active-low; a low row means the key in the driven column is pressed.
    assign pressed_raw = ~rows_s_q;
    assign sample_en   = (settle_q == SettleLast);

    // Scan sequencing: hold each column for SettleCycles clocks, then step to the next.
    always_comb begin
        settle_d = settle_q + SetW'(1);
        col_d    = col_q;
        if (sample_en) begin
            settle_d = '0;
            col_d    = (col_q == ColLast) ? '0 : col_q + ColW'(1);
        end
    end

    // Per-key debounce, applied only to the keys of the column being sampled.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sample_en) begin
            for (int unsigned r = 0; r < Rows; r++) begin
                for (int unsigned c = 0; c < Cols; c++) begin
                    if (ColW'(c) == col_q) begin
                        if (pressed_raw[r] == stable_q[r*Cols+c]) begin
                            // An agreeing sample cancels any pending flip.
                            cnt_d[r*Cols+c] = '0;
                        end else if (cnt_q[r*Cols+c] == CntLast) begin
                            stable_d[r*Cols+c] = ~stable_q[r*Cols+c];
                            cnt_d[r*Cols+c]    = '0;
                        end else begin
                            cnt_d[r*Cols+c] = cnt_q[r*Cols+c] + CntW'(1);
                        end
                    end
                end
            end
        end
    end

    // Sweep completes when the last column's sample is folded in.
    always_comb begin
        done_d = sample_en && (col_q == ColLast);
    end

    // State registers with synchronous reset; synchroniser resets to "no key pressed".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rows_meta_q <= '1;
            rows_s_q    <= '1;
            col_q       <= '0;
            settle_q    <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            rows_meta_q <= rows_i;
            rows_s_q    <= rows_meta_q;
            col_q       <= col_d;
            settle_q    <= settle_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign cols_o      = ~(Cols'(1) << col_q);
    assign buttons_o   = stable_q;
    assign scan_done_o = done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a physical 4x4 key matrix, checks two DUTs
// (DebounceScans 3 and 1) against a sample-history model every cycle, plus literals.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = 16'h0000;

    logic [3:0]  rows3, rows1, cols3, cols1;
    logic [15:0] btn3, btn1;
    logic        done3, done1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .Rows(4), .Cols(4), .SettleCycles(4), .DebounceScans(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rows_i(rows3),
        .cols_o(cols3), .buttons_o(btn3), .scan_done_o(done3)
    );

    keypad_scanner #(
        .Rows(4), .Cols(4), .SettleCycles(4), .DebounceScans(1)
    ) dut_d1 (
        .clk_i(clk), .rst_i(rst), .rows_i(rows1),
        .cols_o(cols1), .buttons_o(btn1), .scan_done_o(done1)
    );

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    function automatic logic [3:0] rows_for(logic [15:0] k, logic [3:0] cols);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (k[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    assign rows3 = rows_for(keys, cols3);
    assign rows1 = rows_for(keys, cols1);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A key flips once its last D samples all disagree with its current state.
    int unsigned m_cyc = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_btn3, m_btn1;
    logic        m_done;
    logic [15:0] h1 = 16'h0, h2 = 16'h0;
    logic [7:0]  sh[16];
    int unsigned nsh[16];

    function automatic bit flips(logic [7:0] s, int unsigned n, int unsigned d, logic st);
        if (n < d) return 1'b0;
        for (int unsigned i = 0; i < d; i++) if (s[i] == st) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1;
                m_cyc   = 0;
                m_btn3  = '0;
                m_btn1  = '0;
                m_done  = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    sh[k]  = '0;
                    nsh[k] = 0;
                end
            end else if (m_valid) begin
                m_done = 1'b0;
                if (m_cyc % 4 == 3) begin
                    int unsigned col;
                    col = (m_cyc % 16) / 4;
                    // Two-flop synchroniser: the sample reflects the matrix two cycles ago.
                    for (int r = 0; r < 4; r++) begin
                        int unsigned k;
                        k = r * 4 + col;
                        sh[k] = {sh[k][6:0], h2[k]};
                        if (nsh[k] < 8) nsh[k]++;
                        if (flips(sh[k], nsh[k], 3, m_btn3[k])) m_btn3[k] = ~m_btn3[k];
                        if (flips(sh[k], nsh[k], 1, m_btn1[k])) m_btn1[k] = ~m_btn1[k];
                    end
                    m_done = (col == 3);
                end
                m_cyc++;
            end
            h2 = h1;
            h1 = keys;
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                logic [3:0] ec;
                ec = 4'hF & ~(4'b0001 << ((m_cyc % 16) / 4));
                chk("cols", cols3, ec);
                chk("buttons", btn3, m_btn3);
                chk("scan_done", done3, m_done);
                chk("cols_d1", cols1, ec);
                chk("buttons_d1", btn1, m_btn1);
                chk("scan_done_d1", done1, m_done);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(int unsigned n);
        int unsigned guard;
        guard = 0;
        while (m_cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (m_cyc != n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: cycle %0d not reached, at %0d", n, m_cyc);
        end
    endtask

    initial begin
        // Idle sweep.
        do_reset();
        keys = 16'h0000;
        chk("t1_reset_cols", cols3, 4'hE);
        chk("t1_reset_btn", btn3, 16'h0);
        chk("t1_reset_done", done3, 1'b0);
        wait_cyc(15); chk("t1_cols15", cols3, 4'h7);
        wait_cyc(16); chk("t1_done16", done3, 1'b1);
        chk("t1_model_done16", m_done, 1'b1);
        wait_cyc(17); chk("t1_done17", done3, 1'b0);
        wait_cyc(48); chk("t1_done48", done3, 1'b1);
        chk("t1_btn48", btn3, 16'h0);

        // Held key (r1,c2), then release; DebounceScans=1 instance alongside.
        do_reset();
        keys = 16'h0040;
        wait_cyc(11); chk("t6_d1_btn11", btn1, 16'h0);
        wait_cyc(12); chk("t6_d1_btn12", btn1, 16'h0040);
        wait_cyc(43); chk("t2_btn43", btn3, 16'h0);
        wait_cyc(44); chk("t2_btn44", btn3, 16'h0040);
        chk("t2_model_btn44", m_btn3, 16'h0040);
        wait_cyc(48); keys = 16'h0000;
        wait_cyc(59); chk("t6_d1_btn59", btn1, 16'h0040);
        wait_cyc(60); chk("t6_d1_btn60", btn1, 16'h0);
        wait_cyc(91); chk("t3_rel_btn91", btn3, 16'h0040);
        wait_cyc(92); chk("t3_rel_btn92", btn3, 16'h0);

        // Bounced key never propagates with 3-scan debounce.
        do_reset();
        keys = 16'h0040;
        wait_cyc(16); keys = 16'h0000;
        wait_cyc(28); chk("t6_d1_bounce28", btn1, 16'h0);
        wait_cyc(32); keys = 16'h0040;
        wait_cyc(48); keys = 16'h0000;
        wait_cyc(60); chk("t3_bounce60", btn3, 16'h0);
        chk("t3_model_bounce60", m_btn3, 16'h0);

        // Two simultaneous keys.
        do_reset();
        keys = 16'h8001;
        wait_cyc(35); chk("t4_btn35", btn3, 16'h0);
        wait_cyc(36); chk("t4_btn36", btn3, 16'h0001);
        wait_cyc(47); chk("t4_btn47", btn3, 16'h0001);
        wait_cyc(48); chk("t4_btn48", btn3, 16'h8001);

        // Reset mid-scan while a key is reported.
        do_reset();
        keys = 16'h0040;
        wait_cyc(52);
        chk("t5_pre_btn", btn3, 16'h0040);
        chk("t5_pre_cols", cols3, 4'hD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_post_btn", btn3, 16'h0);
        chk("t5_post_cols", cols3, 4'hE);
        wait_cyc(43); chk("t5_btn43", btn3, 16'h0);
        wait_cyc(44); chk("t5_btn44", btn3, 16'h0040);

        // Randomised key activity with occasional resets.
        do_reset();
        keys = 16'h0000;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 799) == 0) rst = 1'b1;
            if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 15)] ^= 1'b1;
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
